// File: rtl/pwm_spi_write_arbiter.sv
// Purpose: round-robin arbiter for four PWM level writers, serialising each granted write as a 24-bit SPI mode-0 frame.
// Latency: grant one cycle after a request is seen in IDLE; done 51*SCLK_DIV cycles after the first SETUP cycle.
// Backpressure: one frame in flight; requests wait (held high) until granted, nothing is granted while busy.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req[3:0]                per-requester write request, held until its grant bit pulses
//   req_chan[7:0]           requester i channel in [2i+1:2i]
//   req_level[31:0]         requester i level in [8i+7:8i]
//   grant[3:0]              one-hot single-cycle accept pulse
//   busy                    frame in progress (grant cycle through end of GAP)
//   done, err, echo[7:0]    end-of-frame pulse, echo mismatch flag, byte read back on miso
//   cs, sclk, mosi, miso    SPI master pins (cs active-low, sclk idle low, MSB first out, LSB first echo in)
module pwm_spi_write_arbiter #(
    parameter int SCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req,
    input  logic [7:0]  req_chan,
    input  logic [31:0] req_level,
    output logic [3:0]  grant,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  echo,
    output logic        cs,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso
);

    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(SCLK_DIV - 1);
    localparam logic [7:0] DIV_PRE  = 8'(SCLK_DIV - 2);

    state_t      state;
    logic [1:0]  rr_ptr;
    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic [23:0] frame_sr;
    logic [7:0]  level_q;
    logic [7:0]  rx_sr;

    logic        pick_vld;
    logic [1:0]  pick_idx;
    logic [1:0]  pick_chan;
    logic [7:0]  pick_level;
    logic        div_end;

    // Scan from the farthest offset down so the requester closest to rr_ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = rr_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (req[rr_ptr + 2'(i)]) begin
                pick_vld = 1'b1;
                pick_idx = rr_ptr + 2'(i);
            end
        end
    end

    assign pick_chan  = req_chan[{pick_idx, 1'b0} +: 2];
    assign pick_level = req_level[{pick_idx, 3'b000} +: 8];
    assign div_end    = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rr_ptr   <= 2'd0;
            div_cnt  <= 8'd0;
            bit_cnt  <= 5'd0;
            frame_sr <= 24'd0;
            level_q  <= 8'd0;
            rx_sr    <= 8'd0;
            grant    <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            echo     <= 8'd0;
            cs       <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
        end else begin
            grant   <= 4'd0;
            done    <= 1'b0;
            div_cnt <= div_end ? 8'd0 : div_cnt + 8'd1;
            case (state)
                IDLE: begin
                    div_cnt <= 8'd0;
                    if (pick_vld) begin
                        grant    <= 4'b0001 << pick_idx;
                        rr_ptr   <= pick_idx + 2'd1;
                        level_q  <= pick_level;
                        frame_sr <= {1'b1, 5'b00000, pick_chan, pick_level, 8'h00};
                        rx_sr    <= 8'd0;
                        bit_cnt  <= 5'd0;
                        mosi     <= 1'b1;   // frame bit 23 is always the write flag
                        cs       <= 1'b0;
                        sclk     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_end) state <= LOW;
                end
                LOW: begin
                    if (div_end) begin
                        sclk  <= 1'b1;
                        state <= HIGH;
                        // Echo arrives LSB first during the third byte; shift in from the top.
                        if (bit_cnt >= 5'd16) rx_sr <= {miso, rx_sr[7:1]};
                    end
                end
                HIGH: begin
                    if (div_end) begin
                        sclk     <= 1'b0;
                        bit_cnt  <= bit_cnt + 5'd1;
                        frame_sr <= frame_sr << 1;
                        mosi     <= frame_sr[22];
                        state    <= (bit_cnt == 5'd23) ? HOLD : LOW;
                    end
                end
                HOLD: begin
                    if (div_end) begin
                        cs    <= 1'b1;
                        state <= GAP;
                    end
                end
                GAP: begin
                    // Registered done: raise it one cycle early so it is seen on the last GAP cycle.
                    if (div_cnt == DIV_PRE) begin
                        done <= 1'b1;
                        echo <= rx_sr;
                        err  <= (rx_sr != level_q);
                    end
                    if (div_end) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_spi_write_arbiter.sv
// Purpose: directed self-checking bench for pwm_spi_write_arbiter with a PWM-driver SPI slave model per instance.
// Latency: instance a uses SCLK_DIV=4 (204-cycle frames), instance b uses SCLK_DIV=2 (102-cycle frames).
// Backpressure: requesters hold req until their grant bit is seen, then drop it.
module tb_pwm_spi_write_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [3:0]  req_a, grant_a, req_b, grant_b;
    logic [7:0]  chan_a, echo_a, chan_b, echo_b;
    logic [31:0] lvl_a, lvl_b;
    logic        busy_a, done_a, err_a, cs_a, sclk_a, mosi_a, miso_a;
    logic        busy_b, done_b, err_b, cs_b, sclk_b, mosi_b, miso_b;
    logic        force_zero;

    int n_chk = 0;
    int n_fail = 0;

    pwm_spi_write_arbiter #(.SCLK_DIV(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .req(req_a), .req_chan(chan_a), .req_level(lvl_a),
        .grant(grant_a), .busy(busy_a), .done(done_a), .err(err_a), .echo(echo_a),
        .cs(cs_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a)
    );

    pwm_spi_write_arbiter #(.SCLK_DIV(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .req(req_b), .req_chan(chan_b), .req_level(lvl_b),
        .grant(grant_b), .busy(busy_b), .done(done_b), .err(err_b), .echo(echo_b),
        .cs(cs_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b)
    );

    // PWM driver model: shifts mosi on sclk rise, echoes the written level LSB first
    // during byte2, and commits the write on cs rise only after a full 24-bit frame.
    logic [4:0]  a_bits = 5'd0;
    logic [23:0] a_sr = 24'd0;
    logic [23:0] a_last = 24'd0;
    logic [7:0]  a_lvl = 8'd0;
    logic        a_cs_q = 1'b1;
    logic        a_sclk_q = 1'b0;
    logic [7:0]  a_regs [4] = '{default: 8'h00};
    int          a_wr = 0;

    always @(posedge clk) begin
        a_cs_q   <= cs_a;
        a_sclk_q <= sclk_a;
        if (cs_a) begin
            a_bits <= 5'd0;
            if (!a_cs_q && a_bits == 5'd24) begin
                a_regs[a_sr[17:16]] <= a_sr[15:8];
                a_last <= a_sr;
                a_wr   <= a_wr + 1;
            end
        end else if (sclk_a && !a_sclk_q) begin
            a_sr   <= {a_sr[22:0], mosi_a};
            a_bits <= a_bits + 5'd1;
            if (a_bits == 5'd15) a_lvl <= {a_sr[6:0], mosi_a};
        end
    end
    assign miso_a = force_zero ? 1'b0 :
                    ((a_bits >= 5'd16 && a_bits < 5'd24) ? a_lvl[a_bits[2:0]] : 1'b0);

    logic [4:0]  b_bits = 5'd0;
    logic [23:0] b_sr = 24'd0;
    logic [7:0]  b_lvl = 8'd0;
    logic        b_cs_q = 1'b1;
    logic        b_sclk_q = 1'b0;
    logic [7:0]  b_regs [4] = '{default: 8'h00};
    int          b_wr = 0;

    always @(posedge clk) begin
        b_cs_q   <= cs_b;
        b_sclk_q <= sclk_b;
        if (cs_b) begin
            b_bits <= 5'd0;
            if (!b_cs_q && b_bits == 5'd24) begin
                b_regs[b_sr[17:16]] <= b_sr[15:8];
                b_wr <= b_wr + 1;
            end
        end else if (sclk_b && !b_sclk_q) begin
            b_sr   <= {b_sr[22:0], mosi_b};
            b_bits <= b_bits + 5'd1;
            if (b_bits == 5'd15) b_lvl <= {b_sr[6:0], mosi_b};
        end
    end
    assign miso_b = (b_bits >= 5'd16 && b_bits < 5'd24) ? b_lvl[b_bits[2:0]] : 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a grant pulse, then drops the granted request bit.
    task automatic wait_grant(input bit sel, output logic [3:0] g, output int w);
        w = 0;
        while ((sel ? grant_b : grant_a) == 4'd0 && w < 600) begin
            @(negedge clk);
            w++;
        end
        g = sel ? grant_b : grant_a;
        chk(sel ? "grant_seen_b" : "grant_seen_a", 32'(g != 4'd0), 32'd1);
        if (sel) req_b = req_b & ~g;
        else     req_a = req_a & ~g;
    endtask

    // Counts cycles from the current one (cycle 1) up to and including the done cycle.
    task automatic wait_done(input bit sel, output int n);
        n = 1;
        while (!(sel ? done_b : done_a) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(sel ? "done_seen_b" : "done_seen_a", 32'(sel ? done_b : done_a), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] g;
        logic [3:0] seen;
        int w, n, k, c, p, wr0;

        reset_n = 1'b0;
        req_a = 4'd0; chan_a = 8'd0; lvl_a = 32'd0;
        req_b = 4'd0; chan_b = 8'd0; lvl_b = 32'd0;
        force_zero = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_cs", 32'(cs_a), 32'd1);
        chk("rst_sclk", 32'(sclk_a), 32'd0);
        chk("rst_mosi", 32'(mosi_a), 32'd0);
        chk("rst_grant", 32'(grant_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done_err_echo", 32'({done_a, err_a, echo_a}), 32'd0);
        chk("rst_cs_b", 32'(cs_b), 32'd1);
        reset_n = 1'b1;

        // Basic write: chan 2, level 0x5A
        chan_a = 8'h02; lvl_a = 32'h0000_005A; req_a = 4'b0001;
        wait_grant(0, g, w);
        chk("basic_grant", 32'(g), 32'h1);
        chk("basic_busy", 32'(busy_a), 32'd1);
        chk("basic_cs_low", 32'(cs_a), 32'd0);
        wait_done(0, n);
        chk("basic_frame_len", 32'(n), 32'd204);
        chk("basic_echo", 32'(echo_a), 32'h5A);
        chk("basic_err", 32'(err_a), 32'd0);
        chk("basic_mosi_stream", 32'(a_last), 32'h825A00);
        chk("basic_drv_ch2", 32'(a_regs[2]), 32'h5A);
        chk("basic_wr_cnt", 32'(a_wr), 32'd1);
        @(negedge clk);
        chk("basic_busy_clear", 32'(busy_a), 32'd0);

        // Round robin from rr_ptr=0 with all four requesting, then requester 1 re-raised
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chan_a = 8'hE4; lvl_a = 32'h4433_2211; req_a = 4'b1111;
        wait_grant(0, g, w);
        chk("rr_first", 32'(g), 32'h1);
        wait_done(0, n);
        chk("done_no_same_grant", 32'(grant_a), 32'd0);
        wait_grant(0, g, w);
        chk("rr_second", 32'(g), 32'h2);
        chk("rr_b2b_latency", 32'(w), 32'd2);
        req_a[1] = 1'b1;
        wait_done(0, n);
        wait_grant(0, g, w);
        chk("rr_third", 32'(g), 32'h4);
        wait_done(0, n);
        wait_grant(0, g, w);
        chk("rr_fourth", 32'(g), 32'h8);
        wait_done(0, n);
        wait_grant(0, g, w);
        chk("rr_rereq_1", 32'(g), 32'h2);
        wait_done(0, n);
        chk("rr_drv_ch0", 32'(a_regs[0]), 32'h11);
        chk("rr_drv_ch1", 32'(a_regs[1]), 32'h22);
        chk("rr_drv_ch2", 32'(a_regs[2]), 32'h33);
        chk("rr_drv_ch3", 32'(a_regs[3]), 32'h44);

        // Request raised and withdrawn while busy is never granted
        lvl_a = 32'h4433_2277; req_a = 4'b0001;
        wait_grant(0, g, w);
        chk("wd_grant0", 32'(g), 32'h1);
        repeat (20) @(negedge clk);
        req_a[3] = 1'b1;
        repeat (20) @(negedge clk);
        req_a[3] = 1'b0;
        wait_done(0, n);
        seen = 4'd0;
        repeat (30) begin
            @(negedge clk);
            seen = seen | grant_a;
        end
        chk("wd_no_grant", 32'(seen), 32'd0);
        chk("wd_busy_idle", 32'(busy_a), 32'd0);
        chk("wd_drv_ch0", 32'(a_regs[0]), 32'h77);

        // Echo forced to zero during byte2 with level 0xFF
        lvl_a = 32'h44FF_2277; req_a = 4'b0100; force_zero = 1'b1;
        wait_grant(0, g, w);
        chk("err_grant2", 32'(g), 32'h4);
        wait_done(0, n);
        chk("err_flag", 32'(err_a), 32'd1);
        chk("err_echo", 32'(echo_a), 32'h00);
        force_zero = 1'b0;
        chk("err_drv_ch2", 32'(a_regs[2]), 32'hFF);

        // Reset at bit 10 aborts the frame
        chan_a = 8'hE7; lvl_a = 32'h44FF_22C3; req_a = 4'b0001;
        wait_grant(0, g, w);
        chk("abort_grant0", 32'(g), 32'h1);
        k = 0;
        while (a_bits != 5'd10 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("abort_at_bit10", 32'(a_bits), 32'd10);
        wr0 = a_wr;
        reset_n = 1'b0;
        #1;
        chk("abort_cs_high", 32'(cs_a), 32'd1);
        chk("abort_sclk_low", 32'(sclk_a), 32'd0);
        chk("abort_busy_low", 32'(busy_a), 32'd0);
        seen = 4'd0;
        repeat (3) begin
            @(negedge clk);
            seen[0] = seen[0] | done_a;
        end
        reset_n = 1'b1;
        chk("abort_no_done", 32'(seen), 32'd0);
        lvl_a = 32'h44FF_223C; req_a = 4'b0001;
        wait_grant(0, g, w);
        chk("abort_first_grant_lat", 32'(w), 32'd1);
        chk("abort_no_commit", 32'(a_wr), 32'(wr0));
        wait_done(0, n);
        chk("abort_retry_len", 32'(n), 32'd204);
        chk("abort_retry_echo", 32'(echo_a), 32'h3C);
        chk("abort_retry_err", 32'(err_a), 32'd0);
        chk("abort_retry_drv_ch3", 32'(a_regs[3]), 32'h3C);

        // SCLK_DIV=2: sclk period, cs gap between back-to-back frames, both writes accepted
        chan_b = 8'h04; lvl_b = 32'h0000_96A5; req_b = 4'b0011;
        wait_grant(1, g, w);
        chk("b_grant0", 32'(g), 32'h1);
        k = 0;
        while (sclk_b !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        p = 0;
        while (sclk_b !== 1'b0 && p < 100) begin
            @(negedge clk);
            p++;
        end
        while (sclk_b !== 1'b1 && p < 100) begin
            @(negedge clk);
            p++;
        end
        chk("b_sclk_period", 32'(p), 32'd4);
        wait_done(1, n);
        chk("b_echo0", 32'(echo_b), 32'hA5);
        c = 0;
        while (cs_b && c < 50) begin
            c++;
            @(negedge clk);
        end
        chk("b_cs_gap_ge2", 32'(c >= 2), 32'd1);
        wait_grant(1, g, w);
        chk("b_grant1", 32'(g), 32'h2);
        wait_done(1, n);
        chk("b_frame_len", 32'(n), 32'd102);
        chk("b_err1", 32'(err_b), 32'd0);
        chk("b_wr_cnt", 32'(b_wr), 32'd2);
        chk("b_drv_ch0", 32'(b_regs[0]), 32'hA5);
        chk("b_drv_ch1", 32'(b_regs[1]), 32'h96);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_spi_write_arbiter.md
PWM_SPI_WRITE_ARBITER -- requirements
Module: pwm_spi_write_arbiter

Interface
REQ-001 Parameter: SCLK_DIV, default 4, clk cycles per SCLK half-period; legal values 2..255.
REQ-002 clk  input  1  sole clock; all logic on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  per-requester write request; held high until the matching grant bit pulses.
REQ-005 req_chan  input  8  requester i target PWM channel in bits [2i+1:2i].
REQ-006 req_level  input  32  requester i PWM level in bits [8i+7:8i].
REQ-007 grant  output  4  one-hot, one-cycle pulse; request accepted and operands latched.
REQ-008 busy  output  1  high from grant cycle until the end of the GAP state.
REQ-009 done  output  1  one-cycle pulse at end of frame.
REQ-010 err  output  1  valid with done; high if the echoed byte differs from the written level.
REQ-011 echo  output  8  byte read back on miso, updated with done.
REQ-012 cs  output  1  SPI chip select to the PWM driver, active-low, idle high.
REQ-013 sclk  output  1  SPI clock, idle low (mode 0).
REQ-014 mosi  output  1  SPI data out, MSB first.
REQ-015 miso  input  1  SPI data in, LSB first echo from the PWM driver.

Function
REQ-016 States: IDLE, SETUP, LOW, HIGH, HOLD, GAP; exactly one active per cycle.
REQ-017 IDLE: when any req bit is high, grant the first requester at or after rr_ptr (wrapping 3->0), pulse grant, latch chan and level, enter SETUP.
REQ-018 rr_ptr becomes (granted index + 1) mod 4 on each grant; it is 0 after reset.
REQ-019 Requests are ignored outside IDLE; no grant is issued while busy.
REQ-020 Frame is 24 bits: byte0 = {1'b1, 5'b0, chan}, byte1 = level, byte2 = 8'h00.
REQ-021 SETUP: cs low, sclk low, mosi = frame bit 23, lasts SCLK_DIV cycles, then LOW.
REQ-022 LOW: sclk low for SCLK_DIV cycles; mosi is set to the current bit on the first cycle and held stable through the following HIGH.
REQ-023 HIGH: sclk high for SCLK_DIV cycles; afterwards the 5-bit bit counter increments; enter LOW if the count is below 24, else HOLD.
REQ-024 During byte2 (bits 16..23), miso is sampled on the last cycle of each LOW phase; the sample for bit 16+k becomes echo bit k.
REQ-025 HOLD: cs low, sclk low for SCLK_DIV cycles, then cs goes high and the block enters GAP.
REQ-026 GAP: cs high for SCLK_DIV cycles; done pulses on the last GAP cycle together with err and echo; then IDLE with busy low.
REQ-027 Frame length is 51*SCLK_DIV cycles from the first SETUP cycle to the last GAP cycle inclusive.
REQ-028 A req bit falling before its grant withdraws the request without error.
REQ-029 When req is high in the same cycle that done pulses, the grant happens the next cycle (from IDLE), never in the same cycle.

Reset
REQ-030 reset_n low forces IDLE, rr_ptr=0, cs=1, sclk=0, mosi=0, grant=0, busy=0, done=0, err=0, echo=0 asynchronously.
REQ-031 Reset asserted mid-frame aborts the frame with no done pulse; the cs=1 level resets the slave SPI state.
REQ-032 After reset_n deasserts, the first grant is possible on the first clock edge in IDLE.

Verification
REQ-033 SCLK_DIV=4; req=0001, chan0=2, level0=0x5A, with the PWM driver model attached -> mosi stream 0x82,0x5A,0x00; done after 204 cycles; echo=0x5A; err=0; driver channel 2 level = 0x5A.
REQ-034 req=1111 held -> grants in the order 0,1,2,3; after requester 1 is re-raised, the next grant goes to 1 only when it is reached from rr_ptr.
REQ-035 miso forced to 0 during byte2, level=0xFF -> done with err=1 and echo=0x00.
REQ-036 reset_n pulsed low at bit 10 of a frame -> cs=1 and sclk=0 immediately, no done; a new request completes correctly afterwards.
REQ-037 SCLK_DIV=2 -> sclk period is 4 clk cycles; cs high between back-to-back frames for at least 2 cycles; driver accepts both writes.
